// File: rtl/vector_mem_seq_pkg.sv
// Shared instruction codes, geometry and sequencer state encoding for the vector memory path.
// Operand selection imports the same functype codes, so keep them in sync.
package vector_mem_seq_pkg;

    localparam int ELEMS  = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int VEC_W  = ELEMS * DATA_W;
    localparam int IDX_W  = $clog2(ELEMS);

    localparam logic [3:0] FT_VADD = 4'b0000;
    localparam logic [3:0] FT_VSUB = 4'b0001;
    localparam logic [3:0] FT_VMUL = 4'b0010;
    localparam logic [3:0] FT_SST  = 4'b0011;
    localparam logic [3:0] FT_VLD  = 4'b0100;
    localparam logic [3:0] FT_VST  = 4'b0101;
    localparam logic [3:0] FT_VDOT = 4'b0110;
    localparam logic [3:0] FT_NOP  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_TAIL,
        ST_WR,
        ST_WR1,
        ST_DONE
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] ft);
        return (ft == FT_VLD) || (ft == FT_VST) || (ft == FT_SST);
    endfunction

endpackage

// File: rtl/vector_mem_seq_addr_gen.sv
// Element address generator: latched base plus wrapping element index.
// Latency: address is combinational from registered base/idx; idx advances one per inc.
// Backpressure: none, the sequencer owns inc.
module vec_addr_gen
    import vector_mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    logic [ADDR_W-1:0] base;

    always_ff @(posedge clk) begin
        if (rst) begin
            base <= '0;
            idx  <= '0;
        end else if (load) begin
            base <= base_in;
            idx  <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    // Carry out of the top bit is dropped so 16'hFFFF wraps to 16'h0000.
    assign addr = base + ADDR_W'(idx);
    assign last = (idx == IDX_W'(ELEMS - 1));

endmodule

// File: rtl/vector_mem_seq.sv
// Sequences VLD/VST/SST accesses onto the single-port 16-bit data memory.
// Latency from start: VLD 18, VST 17, SST 2, unsupported 1 cycle to done.
// Backpressure: busy high while sequencing; start is ignored unless idle.
module vector_mem_seq
    import vector_mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        functype,
    input  logic [VEC_W-1:0]  op1,
    input  logic [VEC_W-1:0]  op2,
    input  logic [VEC_W-1:0]  st_vec,
    input  logic [DATA_W-1:0] st_scalar,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [VEC_W-1:0]  ld_vec,
    output logic              ld_we
);

    state_t             state, state_nxt;
    logic [3:0]         func_q;
    logic [VEC_W-1:0]   st_vec_q;
    logic [DATA_W-1:0]  st_scalar_q;
    logic [VEC_W-1:0]   shadow;
    logic [ADDR_W-1:0]  elem_addr;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic               load;
    logic               inc;
    logic               capture;
    logic               unused_op_hi;

    assign unused_op_hi = ^{op1[VEC_W-1:ADDR_W], op2[VEC_W-1:ADDR_W]};

    assign load = (state == ST_IDLE) && start;
    assign inc  = (state == ST_RD) || (state == ST_WR);

    // Read data lags mem_re by one cycle, so the first RD cycle has nothing to capture.
    assign capture = ((state == ST_RD) && (idx != '0)) || (state == ST_RD_TAIL);

    vec_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .base_in (op1[ADDR_W-1:0] + op2[ADDR_W-1:0]),
        .inc     (inc),
        .addr    (elem_addr),
        .idx     (idx),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (functype)
                        FT_VLD:  state_nxt = ST_RD;
                        FT_VST:  state_nxt = ST_WR;
                        FT_SST:  state_nxt = ST_WR1;
                        default: state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_RD:      if (last) state_nxt = ST_RD_TAIL;
            ST_RD_TAIL: state_nxt = ST_DONE;
            ST_WR:      if (last) state_nxt = ST_DONE;
            ST_WR1:     state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        ld_we     = 1'b0;
        case (state)
            ST_RD: begin
                mem_re   = 1'b1;
                mem_addr = elem_addr;
            end
            ST_WR: begin
                mem_we    = 1'b1;
                mem_addr  = elem_addr;
                mem_wdata = st_vec_q[DATA_W*idx +: DATA_W];
            end
            ST_WR1: begin
                mem_we    = 1'b1;
                mem_addr  = elem_addr;
                mem_wdata = st_scalar_q;
            end
            ST_DONE: begin
                done  = 1'b1;
                ld_we = (func_q == FT_VLD);
                err   = !is_mem_op(func_q);
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Elements shift in from the top; after 16 captures element 0 sits in the low word.
    always_ff @(posedge clk) begin
        if (rst) begin
            func_q      <= '0;
            st_vec_q    <= '0;
            st_scalar_q <= '0;
            shadow      <= '0;
            ld_vec      <= '0;
        end else begin
            if (load) begin
                func_q      <= functype;
                st_vec_q    <= st_vec;
                st_scalar_q <= st_scalar;
            end
            if (capture)
                shadow <= {mem_rdata, shadow[VEC_W-1:DATA_W]};
            if (state == ST_RD_TAIL)
                ld_vec <= {mem_rdata, shadow[VEC_W-1:DATA_W]};
        end
    end

endmodule

// File: tb/tb_vector_mem_seq.sv
// Directed bench for vector_mem_seq: table of single operations plus restart and mid-read reset sequences.
module tb_vector_mem_seq;
    import vector_mem_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        functype;
    logic [VEC_W-1:0]  op1, op2, st_vec;
    logic [DATA_W-1:0] st_scalar;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re, mem_we, busy, done, err, ld_we;
    logic [VEC_W-1:0]  ld_vec;

    logic [DATA_W-1:0] mem [65536];
    logic [VEC_W-1:0]  vec_ref;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vector_mem_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .functype  (functype),
        .op1       (op1),
        .op2       (op2),
        .st_vec    (st_vec),
        .st_scalar (st_scalar),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ld_vec    (ld_vec),
        .ld_we     (ld_we)
    );

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sc;
        int          dcyc;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] outs();
        return {mem_re, mem_we, mem_addr, mem_wdata, done, err, ld_we, busy};
    endfunction

    // Starts one operation in the cycle after the previous DONE and checks every cycle to done.
    task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] sc, input int d, input int restart, input int abort);
        logic [15:0]      base;
        logic [VEC_W-1:0] exp_ld, prev_ld;
        logic             e_re, e_we, e_done;
        logic [15:0]      e_addr, e_wd;
        @(negedge clk);
        base    = a + b;
        prev_ld = ld_vec;
        for (int i = 0; i < ELEMS; i++) exp_ld[16*i +: 16] = mem[base + 16'(i)];
        chk("idle_before_start", VEC_W'(busy), VEC_W'(1'b0));
        functype  = f;
        op1       = {{15{16'hDEAD}}, a};
        op2       = {{15{16'h7777}}, b};
        st_vec    = vec_ref;
        st_scalar = sc;
        start     = 1'b1;
        for (int c = 1; c <= d; c++) begin
            @(negedge clk);
            start     = 1'b0;
            functype  = f;
            op1       = {{15{16'hDEAD}}, a};
            st_vec    = vec_ref;
            st_scalar = sc;
            e_re   = (f == FT_VLD) && (c <= 16);
            e_we   = ((f == FT_VST) && (c <= 16)) || ((f == FT_SST) && (c == 1));
            e_addr = (e_re || e_we) ? base + 16'(c - 1) : 16'h0;
            e_wd   = 16'h0;
            if (f == FT_VST && c <= 16) e_wd = vec_ref[16*(c-1) +: 16];
            if (f == FT_SST && c == 1)  e_wd = sc;
            e_done = (c == d);
            chk($sformatf("cycle%0d_f%0h", c, f), VEC_W'(outs()),
                VEC_W'({e_re, e_we, e_addr, e_wd, e_done, e_done && !is_mem_op(f),
                        e_done && (f == FT_VLD), 1'b1}));
            if (c == restart) begin
                start     = 1'b1;
                functype  = FT_VLD;
                op1       = '1;
                st_vec    = '1;
                st_scalar = 16'h0;
            end
            if (c == abort) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("reset_mid_op_outs", VEC_W'(outs()), VEC_W'(38'h0));
                chk("reset_mid_op_ldvec", ld_vec, '0);
                return;
            end
        end
        if (f == FT_VLD) chk("ld_vec_assembled", ld_vec, exp_ld);
        else             chk("ld_vec_held", ld_vec, prev_ld);
        if (f == FT_VST)
            for (int i = 0; i < ELEMS; i++)
                chk($sformatf("vst_mem_%0d", i), VEC_W'(mem[base + 16'(i)]), VEC_W'(vec_ref[16*i +: 16]));
        if (f == FT_SST) chk("sst_mem", VEC_W'(mem[base]), VEC_W'(sc));
    endtask

    initial begin
        logic [VEC_W-1:0] tmp;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        for (int i = 0; i < ELEMS; i++) mem[16'h00FE + i] = 16'hA000 + 16'(i);
        for (int i = 0; i < ELEMS; i++) vec_ref[16*i +: 16] = 16'(i) * 16'h1111;

        tbl[0] = '{FT_VLD,  16'h0100, 16'hFFFE, 16'h0000, 18};
        tbl[1] = '{FT_VST,  16'hFFF8, 16'h0000, 16'h0000, 17};
        tbl[2] = '{FT_SST,  16'h0040, 16'h0003, 16'hBEEF, 2};
        tbl[3] = '{FT_VADD, 16'h1234, 16'h0001, 16'h0000, 1};
        tbl[4] = '{FT_NOP,  16'h0000, 16'h0000, 16'h0000, 1};

        rst = 1'b1; start = 1'b0; functype = '0; op1 = '0; op2 = '0;
        st_vec = '0; st_scalar = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", VEC_W'(outs()), VEC_W'(38'h0));
        chk("reset_ldvec", ld_vec, '0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++)
            run_op(tbl[t].f, tbl[t].a, tbl[t].b, tbl[t].sc, tbl[t].dcyc, 0, 0);

        tmp = ld_vec;
        chk("vld_elem0", VEC_W'(tmp[15:0]), VEC_W'(16'hA000));
        chk("vld_elem15", VEC_W'(tmp[255:240]), VEC_W'(16'hA00F));
        chk("vst_wrap_elem15", VEC_W'(mem[16'h0007]), VEC_W'(16'hFFFF));
        chk("vst_elem0", VEC_W'(mem[16'hFFF8]), VEC_W'(16'h0000));
        chk("sst_word", VEC_W'(mem[16'h0043]), VEC_W'(16'hBEEF));

        run_op(FT_VST, 16'h2000, 16'h0000, 16'h0000, 17, 6, 0);
        run_op(FT_VLD, 16'h0100, 16'hFFFE, 16'h0000, 18, 0, 9);
        run_op(FT_VLD, 16'h0105, 16'h0000, 16'h0000, 18, 0, 0);
        tmp = ld_vec;
        chk("fresh_vld_elem0", VEC_W'(tmp[15:0]), VEC_W'(16'hA007));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
